// File: rtl/gppcu_instr_fetch.sv
// gppcu_instr_fetch
// Fetch/issue stage in front of the GPPCU instruction decoder. On a start
// pulse it streams iPROG_LEN words out of a 1-cycle-latency synchronous
// instruction RAM, beginning at iSTART_PC, and presents them in program order
// as opcode + operand + PC. An output register plus one skid register absorb
// the read that is already in flight when execute stalls, so no word is lost.
// At most two words are in flight or buffered at any time.
module gppcu_instr_fetch #(
  parameter int IADDR_W = 10,
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 5
) (
  input  logic                       iCLK,
  input  logic                       iRSTn,
  input  logic                       iSTART,
  input  logic [IADDR_W-1:0]         iSTART_PC,
  input  logic [IADDR_W:0]           iPROG_LEN,
  input  logic                       iSTALL,
  output logic                       oIMEM_RD,
  output logic [IADDR_W-1:0]         oIMEM_ADDR,
  input  logic [INSTR_W-1:0]         iIMEM_DATA,
  output logic                       oVALID,
  output logic [OPC_W-1:0]           oOPC,
  output logic [INSTR_W-OPC_W-1:0]   oOPERAND,
  output logic [IADDR_W-1:0]         oPC,
  output logic                       oBUSY,
  output logic                       oDONE
);

  // Counters are one bit wider than the address so a full 2**IADDR_W sweep
  // can be expressed and compared without overflow.
  localparam int CNT_W = IADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;

  // Program descriptor and progress counters
  logic [IADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [CNT_W-1:0]     consumed_q, consumed_d;

  // Read in flight: the RAM returns its word during the cycle after the strobe
  logic                 inflight_q, inflight_d;
  logic [IADDR_W-1:0]   inflight_pc_q, inflight_pc_d;

  // Output slot seen by the decoder
  logic                 out_valid_q, out_valid_d;
  logic [INSTR_W-1:0]   out_word_q, out_word_d;
  logic [IADDR_W-1:0]   out_pc_q, out_pc_d;

  // Skid slot: catches the returning word when the output slot is stalled
  logic                 skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0]   skid_word_q, skid_word_d;
  logic [IADDR_W-1:0]   skid_pc_q, skid_pc_d;

  // Handshake terms shared by the blocks below
  logic                 start_accept;
  logic                 cons;
  logic                 issue;
  logic [1:0]           occ;
  logic [1:0]           occ_left;
  logic [IADDR_W-1:0]   issue_addr;

  // Decide whether a start is taken, whether a word is consumed, and whether a read issues
  always_comb begin
    start_accept = (state_q == ST_IDLE) && iSTART;
    cons         = out_valid_q && !iSTALL;
    // Words held or on their way: output slot, skid slot, and the pending read.
    occ          = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(inflight_q);
    // A word consumed this edge frees its slot in time for a new read.
    occ_left     = occ - 2'(cons);
    // Address arithmetic wraps naturally at IADDR_W bits.
    issue_addr   = base_q + issued_q[IADDR_W-1:0];
    issue        = (state_q == ST_RUN) && (issued_q < len_q) && (occ_left < 2'd2);
  end

  assign oIMEM_RD   = issue;
  assign oIMEM_ADDR = issue ? issue_addr : '0;

  // Latch the program on start and advance the issue/consume counters
  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q + CNT_W'(issue);
    consumed_d = consumed_q + CNT_W'(cons);
    if (start_accept) begin
      base_d     = iSTART_PC;
      len_d      = iPROG_LEN;
      issued_d   = '0;
      consumed_d = '0;
    end
  end

  // Steer the returning word into the output or skid slot, keeping program order
  always_comb begin
    out_valid_d   = out_valid_q;
    out_word_d    = out_word_q;
    out_pc_d      = out_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_word_d   = skid_word_q;
    skid_pc_d     = skid_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue_addr;

    if (skid_valid_q) begin
      // The skid word is older than anything in flight, so it must go out first.
      if (cons) begin
        out_word_d = skid_word_q;
        out_pc_d   = skid_pc_q;
        if (inflight_q) begin
          skid_word_d = iIMEM_DATA;
          skid_pc_d   = inflight_pc_q;
        end else begin
          skid_valid_d = 1'b0;
        end
      end
      // Skid full with no consume and a read returning cannot occur: the issue
      // rule never lets more than two words be held or in flight.
    end else if (inflight_q) begin
      if (!out_valid_q || cons) begin
        out_valid_d = 1'b1;
        out_word_d  = iIMEM_DATA;
        out_pc_d    = inflight_pc_q;
      end else begin
        skid_valid_d = 1'b1;
        skid_word_d  = iIMEM_DATA;
        skid_pc_d    = inflight_pc_q;
      end
    end else if (cons) begin
      // Slot drained with nothing behind it; word/PC keep their last value.
      out_valid_d = 1'b0;
    end
  end

  // Sequence IDLE -> RUN -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Even a zero-length program spends one cycle in RUN, where nothing can
      // issue and the completion test below fires immediately.
      ST_IDLE: if (start_accept) state_d = ST_RUN;
      // Leave RUN on the same edge that consumes the final instruction.
      ST_RUN:  if (consumed_d == len_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register all state; an active-low reset drops the program and any buffered words
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      consumed_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_valid_q   <= 1'b0;
      out_word_q    <= '0;
      out_pc_q      <= '0;
      skid_valid_q  <= 1'b0;
      skid_word_q   <= '0;
      skid_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      consumed_q    <= consumed_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      out_valid_q   <= out_valid_d;
      out_word_q    <= out_word_d;
      out_pc_q      <= out_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_word_q   <= skid_word_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

  assign oVALID   = out_valid_q;
  assign oOPC     = out_word_q[INSTR_W-1 -: OPC_W];
  assign oOPERAND = out_word_q[INSTR_W-OPC_W-1:0];
  assign oPC      = out_pc_q;
  assign oBUSY    = (state_q != ST_IDLE);
  assign oDONE    = (state_q == ST_DONE);

endmodule

// File: tb/tb_gppcu_instr_fetch.sv
// Bench for gppcu_instr_fetch: directed start/stall/wrap/zero/reset scenarios
// plus randomized programs and stall patterns, checked against a count-based
// reference model (words issued, returned and consumed) and a RAM image.
module tb_gppcu_instr_fetch;

  localparam int IADDR_W = 10;
  localparam int INSTR_W = 32;
  localparam int OPC_W   = 5;
  localparam int OPR_W   = INSTR_W - OPC_W;
  localparam int DEPTH   = 1 << IADDR_W;

  logic                 iCLK = 1'b0;
  logic                 iRSTn = 1'b0;
  logic                 iSTART = 1'b0;
  logic [IADDR_W-1:0]   iSTART_PC = '0;
  logic [IADDR_W:0]     iPROG_LEN = '0;
  logic                 iSTALL = 1'b0;
  logic                 oIMEM_RD;
  logic [IADDR_W-1:0]   oIMEM_ADDR;
  logic [INSTR_W-1:0]   iIMEM_DATA;
  logic                 oVALID;
  logic [OPC_W-1:0]     oOPC;
  logic [OPR_W-1:0]     oOPERAND;
  logic [IADDR_W-1:0]   oPC;
  logic                 oBUSY;
  logic                 oDONE;

  logic [INSTR_W-1:0]   mem [DEPTH];
  logic [INSTR_W-1:0]   last_word;
  int                   n_checks = 0;
  int                   n_pass = 0;

  gppcu_instr_fetch #(.IADDR_W(IADDR_W), .INSTR_W(INSTR_W), .OPC_W(OPC_W)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iSTART(iSTART), .iSTART_PC(iSTART_PC),
    .iPROG_LEN(iPROG_LEN), .iSTALL(iSTALL), .oIMEM_RD(oIMEM_RD),
    .oIMEM_ADDR(oIMEM_ADDR), .iIMEM_DATA(iIMEM_DATA), .oVALID(oVALID),
    .oOPC(oOPC), .oOPERAND(oOPERAND), .oPC(oPC), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  // Synchronous RAM: data valid only the cycle after a strobe, garbage otherwise.
  always @(posedge iCLK) iIMEM_DATA <= oIMEM_RD ? mem[oIMEM_ADDR] : $urandom;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Runs one program and checks every cycle against the count-based model.
  task automatic run_prog(input int base, input int len, input int pct,
                          input int wlo, input int whi, input string tag,
                          output int done_c);
    int issued, consumed, prev1, prev2, limit, c, pc_exp;
    bit run, in_done, stall, exp_valid, cons, exp_rd;
    logic [IADDR_W-1:0] exp_addr;
    issued = 0; consumed = 0; prev1 = 0; prev2 = 0; done_c = -1; c = 0;
    limit = 4 * len + 100;
    @(posedge iCLK); #1;
    iSTART = 1'b1; iSTART_PC = 10'(base); iPROG_LEN = 11'(len); iSTALL = 1'b0;
    #1;
    n_checks++; if (oBUSY !== 1'b0) $display("FAIL %s idle_busy c0 got %b want 0", tag, oBUSY); else n_pass++;
    while (1) begin
      c++;
      run     = (done_c < 0);
      in_done = (c == done_c);
      stall   = ((c >= wlo) && (c <= whi)) || (int'($urandom_range(0, 99)) < pct);
      @(posedge iCLK); #1;
      iSTALL    = stall;
      iSTART    = (run || in_done) && ($urandom_range(0, 7) == 0);
      iSTART_PC = 10'($urandom);
      iPROG_LEN = 11'($urandom);
      #1;
      // A read issued in cycle k is presentable from cycle k+2 on.
      exp_valid = (prev2 - consumed) > 0;
      cons      = exp_valid && !stall;
      exp_rd    = run && (issued < len) && ((issued - consumed - int'(cons)) < 2);
      exp_addr  = exp_rd ? 10'((base + issued) % DEPTH) : '0;
      n_checks++; if (oIMEM_RD !== exp_rd) $display("FAIL %s rd c%0d got %b want %b", tag, c, oIMEM_RD, exp_rd); else n_pass++;
      n_checks++; if (oIMEM_ADDR !== exp_addr) $display("FAIL %s addr c%0d got %h want %h", tag, c, oIMEM_ADDR, exp_addr); else n_pass++;
      n_checks++; if (oVALID !== exp_valid) $display("FAIL %s valid c%0d got %b want %b", tag, c, oVALID, exp_valid); else n_pass++;
      n_checks++; if (oBUSY !== (run || in_done)) $display("FAIL %s busy c%0d got %b want %b", tag, c, oBUSY, run || in_done); else n_pass++;
      n_checks++; if (oDONE !== in_done) $display("FAIL %s done c%0d got %b want %b", tag, c, oDONE, in_done); else n_pass++;
      pc_exp = (base + consumed) % DEPTH;
      if (exp_valid) begin
        n_checks++; if (oPC !== 10'(pc_exp)) $display("FAIL %s pc c%0d got %h want %h", tag, c, oPC, 10'(pc_exp)); else n_pass++;
        n_checks++; if ({oOPC, oOPERAND} !== mem[pc_exp]) $display("FAIL %s word c%0d got %h want %h", tag, c, {oOPC, oOPERAND}, mem[pc_exp]); else n_pass++;
        last_word = mem[pc_exp];
      end else begin
        n_checks++; if ({oOPC, oOPERAND} !== last_word) $display("FAIL %s hold c%0d got %h want %h", tag, c, {oOPC, oOPERAND}, last_word); else n_pass++;
      end
      if (cons) consumed++;
      if (exp_rd) issued++;
      prev2 = prev1;
      prev1 = issued;
      if (run && (consumed == len)) done_c = c + 1;
      if ((done_c >= 0) && (c == done_c + 1)) break;
      if (c > limit) begin
        n_checks++;
        $display("FAIL %s timeout after %0d cycles consumed %0d want %0d", tag, c, consumed, len);
        break;
      end
    end
    iSTART = 1'b0;
    iSTALL = 1'b0;
  endtask

  task automatic test_reset();
    iRSTn = 1'b0; iSTART = 1'b0; iSTALL = 1'b0;
    repeat (3) @(posedge iCLK);
    #2;
    n_checks++; if (oIMEM_RD !== 1'b0) $display("FAIL reset rd got %b want 0", oIMEM_RD); else n_pass++;
    n_checks++; if (oIMEM_ADDR !== '0) $display("FAIL reset addr got %h want 0", oIMEM_ADDR); else n_pass++;
    n_checks++; if (oVALID !== 1'b0) $display("FAIL reset valid got %b want 0", oVALID); else n_pass++;
    n_checks++; if ({oOPC, oOPERAND} !== '0) $display("FAIL reset word got %h want 0", {oOPC, oOPERAND}); else n_pass++;
    n_checks++; if (oPC !== '0) $display("FAIL reset pc got %h want 0", oPC); else n_pass++;
    n_checks++; if ({oBUSY, oDONE} !== 2'b00) $display("FAIL reset busy_done got %b want 00", {oBUSY, oDONE}); else n_pass++;
    iRSTn = 1'b1;
    last_word = '0;
  endtask

  // Four-instruction program with fixed opcodes; a second start at 0x100 mid-run must be ignored.
  task automatic test_basic();
    bit exp_rd, exp_valid;
    logic [IADDR_W-1:0] exp_addr;
    for (int i = 0; i < 4; i++) mem[16 + i] = {5'(i + 1), 27'($urandom)};
    @(posedge iCLK); #1;
    iSTART = 1'b1; iSTART_PC = 10'h010; iPROG_LEN = 11'd4; iSTALL = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge iCLK); #1;
      iSTART    = (c == 2);
      iSTART_PC = (c == 2) ? 10'h100 : 10'($urandom);
      iPROG_LEN = 11'($urandom);
      #1;
      exp_rd    = (c >= 1) && (c <= 4);
      exp_addr  = exp_rd ? 10'(16 + c - 1) : '0;
      exp_valid = (c >= 3) && (c <= 6);
      n_checks++; if (oIMEM_RD !== exp_rd) $display("FAIL basic rd c%0d got %b want %b", c, oIMEM_RD, exp_rd); else n_pass++;
      n_checks++; if (oIMEM_ADDR !== exp_addr) $display("FAIL basic addr c%0d got %h want %h", c, oIMEM_ADDR, exp_addr); else n_pass++;
      n_checks++; if (oVALID !== exp_valid) $display("FAIL basic valid c%0d got %b want %b", c, oVALID, exp_valid); else n_pass++;
      n_checks++; if (oBUSY !== (c <= 7)) $display("FAIL basic busy c%0d got %b want %b", c, oBUSY, c <= 7); else n_pass++;
      n_checks++; if (oDONE !== (c == 7)) $display("FAIL basic done c%0d got %b want %b", c, oDONE, c == 7); else n_pass++;
      if (exp_valid) begin
        n_checks++; if (oPC !== 10'(16 + c - 3)) $display("FAIL basic pc c%0d got %h want %h", c, oPC, 10'(16 + c - 3)); else n_pass++;
        n_checks++; if (oOPC !== 5'(c - 2)) $display("FAIL basic opc c%0d got %0d want %0d", c, oOPC, c - 2); else n_pass++;
        n_checks++; if (oOPERAND !== mem[16 + c - 3][OPR_W-1:0]) $display("FAIL basic operand c%0d got %h want %h", c, oOPERAND, mem[16 + c - 3][OPR_W-1:0]); else n_pass++;
      end else if (c >= 7) begin
        n_checks++; if ({oOPC, oOPERAND} !== mem[19]) $display("FAIL basic hold c%0d got %h want %h", c, {oOPC, oOPERAND}, mem[19]); else n_pass++;
      end
    end
    last_word = mem[19];
  endtask

  task automatic test_stall();
    int d;
    run_prog(16, 4, 0, 3, 5, "stall", d);
    n_checks++; if (d !== 10) $display("FAIL stall done_cycle got %0d want 10", d); else n_pass++;
  endtask

  task automatic test_wrap();
    int d;
    run_prog(10'h3FE, 4, 0, 0, -1, "wrap", d);
    n_checks++; if (d !== 7) $display("FAIL wrap done_cycle got %0d want 7", d); else n_pass++;
  endtask

  task automatic test_zero();
    int d;
    run_prog(10'h155, 0, 0, 0, -1, "zero", d);
    n_checks++; if (d !== 2) $display("FAIL zero done_cycle got %0d want 2", d); else n_pass++;
  endtask

  // Reset pulse in cycle 4 of the basic program, then the same program again from scratch.
  task automatic test_reset_midrun();
    int d;
    @(posedge iCLK); #1;
    iSTART = 1'b1; iSTART_PC = 10'h010; iPROG_LEN = 11'd4; iSTALL = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge iCLK); #1;
      iSTART = 1'b0;
      iRSTn  = (c != 4);
    end
    #1;
    n_checks++; if (oIMEM_RD !== 1'b0) $display("FAIL midrst rd got %b want 0", oIMEM_RD); else n_pass++;
    n_checks++; if ({oIMEM_ADDR, oVALID, oOPC, oOPERAND, oPC, oBUSY, oDONE} !== '0)
      $display("FAIL midrst outputs got %h want 0", {oIMEM_ADDR, oVALID, oOPC, oOPERAND, oPC, oBUSY, oDONE}); else n_pass++;
    last_word = '0;
    run_prog(16, 4, 0, 0, -1, "midrst_rerun", d);
    n_checks++; if (d !== 7) $display("FAIL midrst_rerun done_cycle got %0d want 7", d); else n_pass++;
  endtask

  task automatic test_random();
    int d;
    for (int k = 0; k < 12; k++)
      run_prog(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)),
               int'($urandom_range(0, 70)), 0, -1, "random", d);
    run_prog(int'($urandom_range(0, DEPTH - 1)), DEPTH, 25, 0, -1, "sweep", d);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    last_word = '0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
